multicycle_ctrl: RTL

Multi-cycle control unit that sequences the yIF/yID/yEX/yDM/yWB datapath stages for one MIPS-subset instruction at a time. It is the initiator side of the datapath control interface. It decodes the instruction register and drives RegDst, RegWrite, ALUSrc, ALU op, MemRead, MemWrite and Mem2Reg, plus PC, IR and next-PC controls. It also tracks memory wait states, retires instructions and halts on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS-subset datapath: sequences fetch, decode,
// execute, memory and write-back for one instruction at a time.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic [2:0]  op,
    output logic        imem_req,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Last wait-counter value before the bound is hit.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  funct_q, funct_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic [31:0] retired_q, retired_d;

    logic        retire;
    logic        mem_expired;
    state_e      boundary_state;
    logic        unused_ins;

    assign unused_ins = ^ins[25:6];

    function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
        case (opc)
            OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    assign mem_expired    = !mem_ready && (wait_q == WAIT_LAST);
    assign boundary_state = run ? S_FETCH : S_IDLE;

    // Next-state logic. The wait counter only survives a self-loop in
    // FETCH or MEM, so every entry into those states starts it at zero.
    always_comb begin
        // NOTE: every always_comb target gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (mem_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                opcode_d = ins[31:26];
                funct_d  = ins[5:0];
                if (!is_legal(ins[31:26], ins[5:0])) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (ins[31:26] == OP_J) begin
                    retire  = 1'b1;
                    state_d = boundary_state;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    OP_BEQ: begin
                        retire  = 1'b1;
                        state_d = boundary_state;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = boundary_state;
                    end
                end else if (mem_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = boundary_state;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        retired_d = retired_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            funct_q   <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    // Control decode from the current state and the latched opcode/funct;
    // DECODE looks at ins directly because the latch fills on its closing edge.
    always_comb begin
        pc_we    = 1'b0;
        pc_src   = PC_SEQ;
        ir_we    = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Mem2Reg  = 1'b0;
        op       = ALU_AND;
        imem_req = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SEQ;
                end
            end
            S_DECODE: begin
                if (ins[31:26] == OP_J) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_RTYPE: begin
                        op     = alu_from_funct(funct_q);
                        ALUSrc = 1'b0;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        op     = ALU_ADD;
                        ALUSrc = 1'b1;
                    end
                    OP_BEQ: begin
                        op     = ALU_SUB;
                        pc_src = PC_BRANCH;
                        pc_we  = zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                op     = ALU_ADD;
                ALUSrc = 1'b1;
                if (opcode_q == OP_LW) MemRead = 1'b1;
                // The write strobe is withheld on the edge that declares a timeout.
                if (opcode_q == OP_SW) MemWrite = !mem_expired;
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (opcode_q == OP_RTYPE) begin
                    RegDst = 1'b1;
                    op     = alu_from_funct(funct_q);
                end else begin
                    op     = ALU_ADD;
                    ALUSrc = 1'b1;
                end
                Mem2Reg = (opcode_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;

endmodule
